cpu_step_ctrl: RTL



---
 rtl/cpu_step_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/single-step controller: produces a one-cycle pipeline enable either at a
// fixed divided rate (run) or once per debounced step press, and counts enables.
module cpu_step_ctrl #(
   parameter int unsigned TICK_PERIOD     = 400000,
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic        halt_req,
   output logic        cpu_en,
   output logic [1:0]  mode,
   output logic [31:0] step_count
);

   localparam int unsigned TICK_W   = $clog2(TICK_PERIOD);
   localparam int unsigned CNT_W    = 32;
   localparam int unsigned N_IN     = 2;
   localparam int unsigned IDX_RUN  = 0;
   localparam int unsigned IDX_STEP = 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // Raw asynchronous inputs, index 0 = run switch, index 1 = step button
   logic [N_IN-1:0] raw_in;

   logic [N_IN-1:0][1:0]       sync_q, sync_d;
   logic [N_IN-1:0]            db_q, db_d;
   logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                       step_rise_q, step_rise_d;

   state_e                     state_q, state_d;
   logic [TICK_W-1:0]          tick_q, tick_d;
   logic                       cpu_en_q, cpu_en_d;
   logic [31:0]                step_count_q, step_count_d;

   logic                       run_db;

   assign raw_in = {step_btn, run_sw};
   assign run_db = db_q[IDX_RUN];

   // Two-flop synchronizers followed by per-input debounce counters
   always_comb begin
      sync_d = sync_q;
      db_d   = db_q;
      cnt_d  = '0;
      for (int i = 0; i < N_IN; i++) begin
         sync_d[i] = {sync_q[i][0], raw_in[i]};
         if (sync_q[i][1] != db_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               db_d[i] = ~db_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      step_rise_d = db_d[IDX_STEP] & ~db_q[IDX_STEP];
   end

   // Input conditioning registers
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         db_q        <= '0;
         cnt_q       <= '0;
         step_rise_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         db_q        <= db_d;
         cnt_q       <= cnt_d;
         step_rise_q <= step_rise_d;
      end
   end

   // Mode FSM next-state, tick divider and enable/count generation
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      cpu_en_d     = 1'b0;
      step_count_d = step_count_q;
      case (state_q)
         ST_IDLE: begin
            if (run_db) begin
               state_d = ST_RUN;
               tick_d  = '0;
            end else if (step_rise_q) begin
               cpu_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
               tick_d  = '0;
            end else if (!run_db) begin
               state_d = ST_IDLE;
               tick_d  = '0;
            end else if (tick_q == TICK_LAST) begin
               tick_d   = '0;
               cpu_en_d = 1'b1;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_HALT: begin
            if (step_rise_q && !run_db) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tick_d  = '0;
         end
      endcase
      if (cpu_en_d) begin
         step_count_d = step_count_q + 32'd1;
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         cpu_en_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         cpu_en_q     <= cpu_en_d;
         step_count_q <= step_count_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign mode       = state_q;
   assign step_count = step_count_q;

endmodule
